// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 3-stage core: load-use bubbles,
// redirect flushes and data-memory freezes, plus stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned LDUSE_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_use_rs1_i,
  input  logic        id_use_rs2_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_load_i,
  input  logic        ex_redirect_i,
  input  logic        mem_busy_i,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_stall_o,
  output logic        idex_flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    FLUSH   = 2'd2,
    MEMWAIT = 2'd3
  } state_e;

  localparam logic [2:0] LDUSE_INIT = 3'(LDUSE_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic lu, rs1_hit, rs2_hit;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pc_redirect;

  assign rs1_hit = id_use_rs1_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit = id_use_rs2_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign lu      = ex_load_i && (ex_rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    pc_redirect = 1'b0;
    if (mem_busy_i) begin
      // Freeze everything; cnt is held so the interrupted countdown resumes.
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      if (state_q != MEMWAIT) begin
        ret_d   = state_q;
        state_d = MEMWAIT;
      end
    end else if (ex_redirect_i) begin
      pc_redirect = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_INIT;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        RUN: begin
          if (lu) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            if (LDUSE_CYCLES > 1) begin
              state_d = LDUSE;
              cnt_d   = LDUSE_INIT;
            end
          end
        end
        LDUSE: begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          cnt_d      = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = RUN;
        end
        MEMWAIT: state_d = ret_q;
        default: state_d = RUN;
      endcase
    end
  end

  // Controls are forced low for the whole time reset is held.
  assign pc_stall_o    = pc_stall    && !rst;
  assign ifid_stall_o  = ifid_stall  && !rst;
  assign ifid_flush_o  = ifid_flush  && !rst;
  assign idex_stall_o  = idex_stall  && !rst;
  assign idex_flush_o  = idex_flush  && !rst;
  assign pc_redirect_o = pc_redirect && !rst;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, pc_stall_o};
    flush_cnt_d = flush_cnt_q + {31'd0, pc_redirect_o};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances (LDUSE=1/FLUSH=2 and
// LDUSE=3/FLUSH=3) share inputs; expected values are hand-computed.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, load, redir, busy;

  logic        a_pcs, a_ifs, a_iff, a_ids, a_idf, a_red;
  logic        b_pcs, b_ifs, b_iff, b_ids, b_idf, b_red;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [5:0]  a_ctl, b_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  // ctl bit order: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, pc_redirect
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_REDIR = 6'b001011;
  localparam logic [5:0] C_FLUSH = 6'b001000;
  localparam logic [5:0] C_BUSY  = 6'b110100;

  assign a_ctl = {a_pcs, a_ifs, a_iff, a_ids, a_idf, a_red};
  assign b_ctl = {b_pcs, b_ifs, b_iff, b_ids, b_idf, b_red};

  always #5 clk = ~clk;

  hazard_ctrl #(.LDUSE_CYCLES(1), .FLUSH_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_rd_addr_i(rd), .ex_load_i(load),
    .ex_redirect_i(redir), .mem_busy_i(busy),
    .pc_stall_o(a_pcs), .ifid_stall_o(a_ifs), .ifid_flush_o(a_iff),
    .idex_stall_o(a_ids), .idex_flush_o(a_idf), .pc_redirect_o(a_red),
    .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt)
  );

  hazard_ctrl #(.LDUSE_CYCLES(3), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_rd_addr_i(rd), .ex_load_i(load),
    .ex_redirect_i(redir), .mem_busy_i(busy),
    .pc_stall_o(b_pcs), .ifid_stall_o(b_ifs), .ifid_flush_o(b_iff),
    .idex_stall_o(b_ids), .idex_flush_o(b_idf), .pc_redirect_o(b_red),
    .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic u1, input logic u2,
                       input logic rdr, input logic bsy);
    load = ld; rd = d; rs1 = s1; rs2 = s2; use1 = u1; use2 = u2;
    redir = rdr; busy = bsy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       ld;
    logic [4:0] d, s1, s2;
    logic       u1, u2;
    logic       hit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_s;
    vecs[0] = '{1, 5,  0,  5,  0, 1, 1};
    vecs[1] = '{1, 0,  0,  0,  0, 1, 0};
    vecs[2] = '{1, 0,  0,  5,  0, 1, 0};
    vecs[3] = '{1, 7,  7,  0,  1, 0, 1};
    vecs[4] = '{1, 7,  7,  0,  0, 0, 0};
    vecs[5] = '{0, 5,  0,  5,  0, 1, 0};
    vecs[6] = '{1, 5,  3,  4,  1, 1, 0};
    vecs[7] = '{1, 31, 31, 31, 1, 1, 1};

    // Reset: controls low even with a redirect and a hazard present.
    drive(1, 5, 0, 5, 0, 1, 1, 0);
    cyc(); #1;
    chk("rst_ctl_a", {26'd0, a_ctl}, {26'd0, C_NONE});
    chk("rst_ctl_b", {26'd0, b_ctl}, {26'd0, C_NONE});
    chk("rst_scnt", a_scnt, 32'd0);
    chk("rst_fcnt", a_fcnt, 32'd0);
    rst = 1'b0;
    idle();

    // Load-use detection table on the single-bubble instance.
    exp_s = 0;
    foreach (vecs[i]) begin
      cyc();
      drive(vecs[i].ld, vecs[i].d, vecs[i].s1, vecs[i].s2, vecs[i].u1, vecs[i].u2, 0, 0);
      #1;
      chk($sformatf("lu_ctl[%0d]", i), {26'd0, a_ctl}, {26'd0, vecs[i].hit ? C_LU : C_NONE});
      chk($sformatf("lu_scnt[%0d]", i), a_scnt, 32'(exp_s));
      if (vecs[i].hit) exp_s++;
    end
    cyc(); idle(); #1;
    chk("lu_end_ctl", {26'd0, a_ctl}, {26'd0, C_NONE});
    chk("lu_end_scnt", a_scnt, 32'd3);

    // Redirect with FLUSH_CYCLES=2.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("rd_c0", {26'd0, a_ctl}, {26'd0, C_REDIR});
    cyc(); idle(); #1;
    chk("rd_c1", {26'd0, a_ctl}, {26'd0, C_FLUSH});
    chk("rd_fcnt", a_fcnt, 32'd1);
    cyc(); #1;
    chk("rd_c2", {26'd0, a_ctl}, {26'd0, C_NONE});
    chk("rd_scnt", a_scnt, 32'd0);

    // Redirect beats a simultaneous load-use; second redirect restarts FLUSH.
    do_reset();
    drive(1, 5, 0, 5, 0, 1, 1, 0); #1;
    chk("pri_a", {26'd0, a_ctl}, {26'd0, C_REDIR});
    chk("pri_b", {26'd0, b_ctl}, {26'd0, C_REDIR});
    cyc(); drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("rst2_a_c1", {26'd0, a_ctl}, {26'd0, C_REDIR});
    chk("rst2_fcnt1", a_fcnt, 32'd1);
    cyc(); idle(); #1;
    chk("rst2_a_c2", {26'd0, a_ctl}, {26'd0, C_FLUSH});
    chk("rst2_b_c2", {26'd0, b_ctl}, {26'd0, C_FLUSH});
    chk("rst2_fcnt2", a_fcnt, 32'd2);
    cyc(); #1;
    chk("rst2_a_c3", {26'd0, a_ctl}, {26'd0, C_NONE});
    chk("rst2_b_c3", {26'd0, b_ctl}, {26'd0, C_FLUSH});
    cyc(); #1;
    chk("rst2_b_c4", {26'd0, b_ctl}, {26'd0, C_NONE});
    chk("rst2_b_fcnt", b_fcnt, 32'd2);
    chk("rst2_scnt", a_scnt, 32'd0);

    // Memory wait in the second LDUSE cycle (LDUSE_CYCLES=3).
    do_reset();
    drive(1, 5, 0, 5, 0, 1, 0, 0); #1;
    chk("mw_c0", {26'd0, b_ctl}, {26'd0, C_LU});
    for (int k = 1; k <= 3; k++) begin
      cyc(); drive(0, 0, 0, 0, 0, 0, 0, 1); #1;
      chk($sformatf("mw_busy%0d", k), {26'd0, b_ctl}, {26'd0, C_BUSY});
      chk($sformatf("mw_scnt%0d", k), b_scnt, 32'(k));
    end
    cyc(); idle(); #1;
    chk("mw_c4", {26'd0, b_ctl}, {26'd0, C_NONE});
    cyc(); #1;
    chk("mw_c5", {26'd0, b_ctl}, {26'd0, C_LU});
    cyc(); #1;
    chk("mw_c6", {26'd0, b_ctl}, {26'd0, C_LU});
    cyc(); #1;
    chk("mw_c7", {26'd0, b_ctl}, {26'd0, C_NONE});
    chk("mw_scnt_b", b_scnt, 32'd6);
    chk("mw_scnt_a", a_scnt, 32'd4);

    // Asynchronous reset mid-FLUSH.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1, 0); #1;
    chk("ar_c0", {26'd0, b_ctl}, {26'd0, C_REDIR});
    cyc(); idle(); #1;
    chk("ar_c1", {26'd0, b_ctl}, {26'd0, C_FLUSH});
    rst = 1'b1; redir = 1'b1; #1;
    chk("ar_hold_b", {26'd0, b_ctl}, {26'd0, C_NONE});
    chk("ar_hold_a", {26'd0, a_ctl}, {26'd0, C_NONE});
    chk("ar_fcnt", b_fcnt, 32'd0);
    cyc(); idle(); rst = 1'b0; #1;
    chk("ar_run", {26'd0, b_ctl}, {26'd0, C_NONE});
    cyc(); #1;
    chk("ar_run2", {26'd0, b_ctl}, {26'd0, C_NONE});

    // Stall counter wrap.
    cyc();
    force dut_a.stall_cnt_q = 32'hFFFF_FFFF;
    drive(1, 5, 0, 5, 0, 1, 0, 0); #1;
    chk("wrap_pre", a_scnt, 32'hFFFF_FFFF);
    chk("wrap_ctl", {26'd0, a_ctl}, {26'd0, C_LU});
    release dut_a.stall_cnt_q;
    cyc(); idle(); #1;
    chk("wrap_post", a_scnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
